// File: rtl/fir_lbll_ctrl.sv
// rtl/fir_lbll_ctrl.sv - key load, flush and sample sequencing for a logic-locked FIR
// Serial key shift/commit, RST_CYC-cycle FIR flush, then one sample per SETTLE window.
module fir_lbll_ctrl #(
    parameter int NBITS   = 64,
    parameter int DW      = 32,
    parameter int SETTLE  = 50,
    parameter int RST_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_start,
    input  logic             key_bit,
    input  logic             key_valid,
    output logic             key_ready,
    output logic             key_done,
    output logic [NBITS-1:0] lbll_key,
    output logic             fir_rst,
    output logic [DW-1:0]    fir_inData,
    input  logic [DW-1:0]    fir_outData,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [DW-1:0]    out_data,
    input  logic             out_ready
);

    localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    localparam logic [BW-1:0] BIT_LAST    = BW'(NBITS - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [RW-1:0] FLUSH_LAST  = RW'(RST_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_READY,
        S_SETTLE,
        S_HOLD
    } state_t;

    state_t state_q, state_d;

    // Only the first NBITS-1 bits need storing; the last bit goes straight into lbll_key.
    logic [NBITS-2:0] shift_q;
    logic [NBITS-1:0] shift_d;
    logic [BW-1:0]    bit_cnt_q;
    logic [SW-1:0]    settle_cnt_q;
    logic [RW-1:0]    flush_cnt_q;

    logic clr_bits;
    logic key_beat;
    logic last_beat;
    logic accept;
    logic capture;

    assign shift_d = {shift_q, key_bit};

    always_comb begin
        state_d   = state_q;
        clr_bits  = 1'b0;
        key_beat  = 1'b0;
        last_beat = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        key_ready = 1'b0;
        key_done  = 1'b0;
        fir_rst   = 1'b1;
        in_ready  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (key_start) begin
                    state_d  = S_LOAD;
                    clr_bits = 1'b1;
                end
            end
            S_LOAD: begin
                key_ready = 1'b1;
                if (key_valid) begin
                    key_beat = 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
                        last_beat = 1'b1;
                        state_d   = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                key_done = 1'b1;
                fir_rst  = 1'b0;
                in_ready = ~key_start;
                // A new key request wins over a sample offered in the same cycle.
                if (key_start) begin
                    state_d  = S_LOAD;
                    clr_bits = 1'b1;
                end else if (in_valid) begin
                    accept  = 1'b1;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                key_done = 1'b1;
                fir_rst  = 1'b0;
                if (settle_cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                key_done = 1'b1;
                fir_rst  = 1'b0;
                if (out_ready) begin
                    state_d = S_READY;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            settle_cnt_q <= '0;
            flush_cnt_q  <= '0;
            lbll_key     <= '0;
            fir_inData   <= '0;
            out_data     <= '0;
            out_valid    <= 1'b0;
        end else begin
            state_q <= state_d;

            if (clr_bits) begin
                bit_cnt_q <= '0;
            end else if (key_beat) begin
                bit_cnt_q <= bit_cnt_q + BW'(1);
            end

            if (key_beat) begin
                shift_q <= shift_d[NBITS-2:0];
            end

            if (last_beat) begin
                lbll_key    <= shift_d;
                flush_cnt_q <= FLUSH_LAST;
            end else if (state_q == S_FLUSH && flush_cnt_q != '0) begin
                flush_cnt_q <= flush_cnt_q - RW'(1);
            end

            if (accept) begin
                fir_inData   <= in_data;
                settle_cnt_q <= SETTLE_LAST;
            end else if (state_q == S_SETTLE && settle_cnt_q != '0) begin
                settle_cnt_q <= settle_cnt_q - SW'(1);
            end

            if (capture) begin
                out_data  <= fir_outData;
                out_valid <= 1'b1;
            end else if (state_q == S_HOLD && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_lbll_ctrl.sv
// tb/tb_fir_lbll_ctrl.sv - directed self-checking bench for fir_lbll_ctrl
module tb_fir_lbll_ctrl;

    localparam int NBITS   = 8;
    localparam int DW      = 32;
    localparam int SETTLE  = 4;
    localparam int RST_CYC = 2;
    localparam logic [DW-1:0] MASK = 32'hFFFF0000;

    logic             clk = 1'b0;
    logic             rst;
    logic             key_start;
    logic             key_bit;
    logic             key_valid;
    logic             key_ready;
    logic             key_done;
    logic [NBITS-1:0] lbll_key;
    logic             fir_rst;
    logic [DW-1:0]    fir_inData;
    logic [DW-1:0]    fir_outData;
    logic             in_valid;
    logic [DW-1:0]    in_data;
    logic             in_ready;
    logic             out_valid;
    logic [DW-1:0]    out_data;
    logic             out_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Stand-in for the locked FIR core.
    assign fir_outData = fir_inData ^ MASK;

    fir_lbll_ctrl #(
        .NBITS(NBITS), .DW(DW), .SETTLE(SETTLE), .RST_CYC(RST_CYC)
    ) dut (
        .clk(clk), .rst(rst),
        .key_start(key_start), .key_bit(key_bit), .key_valid(key_valid),
        .key_ready(key_ready), .key_done(key_done), .lbll_key(lbll_key),
        .fir_rst(fir_rst), .fir_inData(fir_inData), .fir_outData(fir_outData),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; key_start = 1'b0; key_bit = 1'b0; key_valid = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        step(); step();
        total++; if (fir_rst !== 1'b1) begin bad++; $display("FAIL rst_fir_rst got=%0h exp=1", fir_rst); end
        total++; if (lbll_key !== 8'h00) begin bad++; $display("FAIL rst_key got=%h exp=00", lbll_key); end
        total++; if (key_done !== 1'b0) begin bad++; $display("FAIL rst_key_done got=%0h exp=0", key_done); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0h exp=0", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0h exp=0", in_ready); end
        total++; if (key_ready !== 1'b0) begin bad++; $display("FAIL rst_key_ready got=%0h exp=0", key_ready); end
        total++; if (fir_inData !== 32'h0) begin bad++; $display("FAIL rst_fir_in got=%h exp=0", fir_inData); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_key_load();
        logic [7:0] kb;
        kb = 8'hB2;
        key_start = 1'b1;
        step();
        key_start = 1'b0;
        total++; if (key_ready !== 1'b1) begin bad++; $display("FAIL ld_key_ready got=%0h exp=1", key_ready); end
        total++; if (fir_rst !== 1'b1) begin bad++; $display("FAIL ld_fir_rst got=%0h exp=1", fir_rst); end
        for (int i = 0; i < 8; i++) begin
            key_valid = 1'b1;
            key_bit   = kb[7-i];
            step();
            key_valid = 1'b0;
            if (i == 3) begin
                step(); step(); step();
                total++; if (key_ready !== 1'b1) begin bad++; $display("FAIL ld_gap_ready got=%0h exp=1", key_ready); end
            end
            if (i == 6) begin
                total++; if (lbll_key !== 8'h00) begin bad++; $display("FAIL ld_partial got=%h exp=00", lbll_key); end
            end
        end
        total++; if (lbll_key !== 8'hB2) begin bad++; $display("FAIL ld_commit got=%h exp=b2", lbll_key); end
        total++; if (key_done !== 1'b0) begin bad++; $display("FAIL ld_done_t got=%0h exp=0", key_done); end
        step();
        total++; if (fir_rst !== 1'b1) begin bad++; $display("FAIL ld_flush_t1 got=%0h exp=1", fir_rst); end
        total++; if (key_done !== 1'b0) begin bad++; $display("FAIL ld_done_t1 got=%0h exp=0", key_done); end
        step();
        total++; if (fir_rst !== 1'b0) begin bad++; $display("FAIL ld_flush_t2 got=%0h exp=0", fir_rst); end
        total++; if (key_done !== 1'b1) begin bad++; $display("FAIL ld_done_t2 got=%0h exp=1", key_done); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ld_in_ready got=%0h exp=1", in_ready); end
        total++; if (key_ready !== 1'b0) begin bad++; $display("FAIL ld_key_ready_off got=%0h exp=0", key_ready); end
    endtask

    task automatic test_sample();
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        step();
        in_valid = 1'b0;
        total++; if (fir_inData !== 32'hDEADBEEF) begin bad++; $display("FAIL smp_fir_in got=%h exp=deadbeef", fir_inData); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL smp_in_ready got=%0h exp=0", in_ready); end
        step(); step(); step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL smp_early got=%0h exp=0", out_valid); end
        step();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL smp_valid got=%0h exp=1", out_valid); end
        total++; if (out_data !== 32'h2152BEEF) begin bad++; $display("FAIL smp_data got=%h exp=2152beef", out_data); end
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (out_data !== 32'h2152BEEF || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                bad++; $display("FAIL smp_hold data=%h valid=%0h in_ready=%0h exp 2152beef/1/0", out_data, out_valid, in_ready);
            end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL smp_drop got=%0h exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL smp_rearm got=%0h exp=1", in_ready); end
    endtask

    task automatic test_ignored_start();
        in_valid = 1'b1;
        in_data  = 32'h12345678;
        step();
        in_valid = 1'b0;
        step();
        key_start = 1'b1;
        step();
        key_start = 1'b0;
        total++; if (key_ready !== 1'b0 || key_done !== 1'b1) begin
            bad++; $display("FAIL ign_state key_ready=%0h key_done=%0h exp 0/1", key_ready, key_done);
        end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ign_early got=%0h exp=0", out_valid); end
        step();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ign_valid got=%0h exp=1", out_valid); end
        total++; if (out_data !== 32'hEDCB5678) begin bad++; $display("FAIL ign_data got=%h exp=edcb5678", out_data); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h0000AAAA;
        step();
        in_data = 32'h5555FFFF;
        step(); step(); step(); step();
        total++; if (out_valid !== 1'b1 || out_data !== 32'hFFFFAAAA) begin
            bad++; $display("FAIL b2b_first valid=%0h data=%h exp 1/ffffaaaa", out_valid, out_data);
        end
        step();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%0h exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        total++; if (fir_inData !== 32'h5555FFFF) begin bad++; $display("FAIL b2b_second_in got=%h exp=5555ffff", fir_inData); end
        step(); step(); step(); step();
        total++; if (out_valid !== 1'b1 || out_data !== 32'hAAAAFFFF) begin
            bad++; $display("FAIL b2b_second valid=%0h data=%h exp 1/aaaaffff", out_valid, out_data);
        end
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_collision();
        logic [7:0] kb;
        kb = 8'h3C;
        key_start = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h55AA55AA;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL col_in_ready got=%0h exp=0", in_ready); end
        step();
        key_start = 1'b0;
        in_valid  = 1'b0;
        total++; if (key_ready !== 1'b1) begin bad++; $display("FAIL col_load got=%0h exp=1", key_ready); end
        total++; if (key_done !== 1'b0) begin bad++; $display("FAIL col_done got=%0h exp=0", key_done); end
        total++; if (fir_inData !== 32'h5555FFFF) begin bad++; $display("FAIL col_fir_in got=%h exp=5555ffff", fir_inData); end
        total++; if (lbll_key !== 8'hB2) begin bad++; $display("FAIL col_old_key got=%h exp=b2", lbll_key); end
        for (int i = 0; i < 8; i++) begin
            key_valid = 1'b1;
            key_bit   = kb[7-i];
            step();
            if (i == 6) begin
                total++; if (lbll_key !== 8'hB2) begin bad++; $display("FAIL col_partial got=%h exp=b2", lbll_key); end
            end
        end
        key_valid = 1'b0;
        total++; if (lbll_key !== 8'h3C) begin bad++; $display("FAIL col_new_key got=%h exp=3c", lbll_key); end
        step(); step();
        total++; if (key_done !== 1'b1) begin bad++; $display("FAIL col_redone got=%0h exp=1", key_done); end
    endtask

    task automatic test_mid_reset();
        bit seen;
        in_valid = 1'b1;
        in_data  = 32'hCAFEF00D;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (lbll_key !== 8'h00) begin bad++; $display("FAIL mr_key got=%h exp=00", lbll_key); end
        total++; if (fir_rst !== 1'b1) begin bad++; $display("FAIL mr_fir_rst got=%0h exp=1", fir_rst); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mr_out_valid got=%0h exp=0", out_valid); end
        total++; if (key_done !== 1'b0 || key_ready !== 1'b0 || in_ready !== 1'b0) begin
            bad++; $display("FAIL mr_idle done=%0h key_ready=%0h in_ready=%0h exp 0/0/0", key_done, key_ready, in_ready);
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid === 1'b1) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL mr_late_valid got=%0h exp=0", seen); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_key_load();
        test_sample();
        test_ignored_start();
        test_back_to_back();
        test_collision();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
